id_ex_hazard_ctrl: RTL and testbench

ID/EX pipeline register combined with load-use hazard control for the 5-stage MIPS pipeline. It sits between decode and execute, and registers the decoded operands and control toward EX. It tracks load/valid status down EX→MEM→WB and generates the decode stall and bubble insertion. It also drives the `USE_MEM_BACK`/`USE_WB_BACK` qualifiers consumed by the EX-stage forwarding unit, so load data is only forwarded once it exists (from WB).

---
 rtl/id_ex_hazard_ctrl.sv | 121 ++++++++++++
 tb/tb_id_ex_hazard_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_hazard_ctrl.sv
// ID/EX pipeline register with load-use hazard detection.
// This block registers decoded operands and control bits into the EX stage.
// It tracks load and valid status through the MEM and WB stages.
// It produces the decode stall and qualifies the forwarding paths so that
// load data is forwarded only from WB, once the data actually exists.
module id_ex_hazard_ctrl #(
  parameter int unsigned DW  = 32,
  parameter int unsigned RW  = 5,
  parameter int unsigned OPW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           hold,
  input  logic           flush,
  input  logic           id_valid,
  input  logic [RW-1:0]  id_rs,
  input  logic [RW-1:0]  id_rt,
  input  logic           id_use_rs,
  input  logic           id_use_rt,
  input  logic [DW-1:0]  id_rd1,
  input  logic [DW-1:0]  id_rd2,
  input  logic [DW-1:0]  id_imm,
  input  logic [RW-1:0]  id_wr_rd,
  input  logic           id_reg_write,
  input  logic           id_mem_read,
  input  logic           id_mem_write,
  input  logic [OPW-1:0] id_alu_op,
  output logic           ex_valid,
  output logic [RW-1:0]  ex_rs,
  output logic [RW-1:0]  ex_rt,
  output logic [DW-1:0]  ex_rd1,
  output logic [DW-1:0]  ex_rd2,
  output logic [DW-1:0]  ex_imm,
  output logic [RW-1:0]  ex_wr_rd,
  output logic           ex_reg_write,
  output logic           ex_mem_read,
  output logic           ex_mem_write,
  output logic [OPW-1:0] ex_alu_op,
  output logic           stall,
  output logic           USE_MEM_BACK,
  output logic           USE_WB_BACK
);

  logic          mem_valid;
  logic          mem_load;
  logic [RW-1:0] mem_wr_rd;
  logic          mem_reg_write;
  logic          wb_valid;

  logic ex_load_c;
  logic mem_load_c;
  logic rs_haz_c;
  logic rt_haz_c;
  logic bubble_c;

  // The producing load is still in flight: in EX, or in MEM with no data yet.
  assign ex_load_c  = ex_valid & ex_mem_read & ex_reg_write;
  assign mem_load_c = mem_valid & mem_load & mem_reg_write;

  // A source is hazardous when it reads a nonzero register that an in-flight load will write.
  always_comb begin
    rs_haz_c = 1'b0;
    rt_haz_c = 1'b0;
    if (id_valid && id_use_rs && (id_rs != '0)) begin
      rs_haz_c = (ex_load_c && (id_rs == ex_wr_rd)) ||
                 (mem_load_c && (id_rs == mem_wr_rd));
    end
    if (id_valid && id_use_rt && (id_rt != '0)) begin
      rt_haz_c = (ex_load_c && (id_rt == ex_wr_rd)) ||
                 (mem_load_c && (id_rt == mem_wr_rd));
    end
  end

  // A taken branch kills the ID instruction, so it overrides the load-use stall.
  assign stall    = ((rs_haz_c | rt_haz_c) & ~flush) | hold;
  assign bubble_c = flush | rs_haz_c | rt_haz_c;

  // Forwarding qualifiers: a load in MEM has no value yet, while anything valid in WB does.
  assign USE_MEM_BACK = mem_valid & ~mem_load;
  assign USE_WB_BACK  = wb_valid;

  // ID/EX register and EX->MEM->WB tracking. The whole block freezes while hold is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid      <= 1'b0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_rd1        <= '0;
      ex_rd2        <= '0;
      ex_imm        <= '0;
      ex_wr_rd      <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_alu_op     <= '0;
      mem_valid     <= 1'b0;
      mem_load      <= 1'b0;
      mem_wr_rd     <= '0;
      mem_reg_write <= 1'b0;
      wb_valid      <= 1'b0;
    end else if (!hold) begin
      ex_rs         <= id_rs;
      ex_rt         <= id_rt;
      ex_rd1        <= id_rd1;
      ex_rd2        <= id_rd2;
      ex_imm        <= id_imm;
      ex_wr_rd      <= id_wr_rd;
      ex_alu_op     <= id_alu_op;
      ex_valid      <= id_valid & ~bubble_c;
      ex_reg_write  <= id_reg_write & id_valid & ~bubble_c;
      ex_mem_read   <= id_mem_read & id_valid & ~bubble_c;
      ex_mem_write  <= id_mem_write & id_valid & ~bubble_c;
      mem_valid     <= ex_valid;
      mem_load      <= ex_mem_read;
      mem_wr_rd     <= ex_wr_rd;
      mem_reg_write <= ex_reg_write;
      wb_valid      <= mem_valid;
    end
  end

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// Bench for id_ex_hazard_ctrl: acts as IF/ID driving small programs,
// honours stall, and checks each cycle against hand-derived expectations.
module tb_id_ex_hazard_ctrl;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic [4:0] wr_rd;
    logic       rw;
    logic       mr;
    logic       mw;
    logic [3:0] alu;
  } instr_t;

  // Per-cycle observation: stall before the edge, EX/forwarding state after it.
  typedef struct packed {
    logic       st;
    logic       v;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       um;
    logic       uw;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst, hold, flush;
  logic        id_valid, id_use_rs, id_use_rt;
  logic [4:0]  id_rs, id_rt, id_wr_rd;
  logic [31:0] id_rd1, id_rd2, id_imm;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic [3:0]  id_alu_op;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [4:0]  ex_rs, ex_rt, ex_wr_rd;
  logic [31:0] ex_rd1, ex_rd2, ex_imm;
  logic [3:0]  ex_alu_op;
  logic        stall, USE_MEM_BACK, USE_WB_BACK;

  int     n_checks = 0;
  int     n_fail   = 0;
  instr_t prog[$];
  int     pc;
  obs_t   sb[$];

  id_ex_hazard_ctrl #(.DW(32), .RW(5), .OPW(4)) dut (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_wr_rd(id_wr_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_alu_op(id_alu_op),
    .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_wr_rd(ex_wr_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_alu_op(ex_alu_op),
    .stall(stall), .USE_MEM_BACK(USE_MEM_BACK), .USE_WB_BACK(USE_WB_BACK)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout n_checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  function automatic instr_t lw(input logic [4:0] d, input logic [4:0] b);
    instr_t i = '0;
    i.valid = 1'b1; i.rs = b; i.rt = d; i.use_rs = 1'b1;
    i.wr_rd = d; i.rw = 1'b1; i.mr = 1'b1;
    return i;
  endfunction

  function automatic instr_t alu(input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
    instr_t i = '0;
    i.valid = 1'b1; i.rs = s; i.rt = t; i.use_rs = 1'b1; i.use_rt = 1'b1;
    i.wr_rd = d; i.rw = 1'b1; i.alu = 4'd2;
    return i;
  endfunction

  function automatic instr_t sw(input logic [4:0] t, input logic [4:0] b);
    instr_t i = '0;
    i.valid = 1'b1; i.rs = b; i.rt = t; i.use_rs = 1'b1; i.use_rt = 1'b1;
    i.mw = 1'b1;
    return i;
  endfunction

  function automatic obs_t e(input logic st, input logic v, input logic [4:0] rd,
                             input logic rw, input logic mr, input logic um, input logic uw);
    obs_t o;
    o.st = st; o.v = v; o.rd = rd; o.rw = rw; o.mr = mr; o.um = um; o.uw = uw;
    return o;
  endfunction

  task automatic drive_instr(input instr_t i);
    id_valid = i.valid; id_rs = i.rs; id_rt = i.rt;
    id_use_rs = i.use_rs; id_use_rt = i.use_rt; id_wr_rd = i.wr_rd;
    id_reg_write = i.rw; id_mem_read = i.mr; id_mem_write = i.mw; id_alu_op = i.alu;
    id_rd1 = $urandom; id_rd2 = $urandom; id_imm = $urandom;
  endtask

  task automatic do_reset();
    rst = 1'b1; hold = 1'b0; flush = 1'b0;
    drive_instr('0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One pipeline cycle: present prog[pc], sample stall, clock, sample EX side.
  task automatic step(input logic fl, input logic hd, output obs_t o);
    instr_t i;
    i = (pc < prog.size()) ? prog[pc] : '0;
    drive_instr(i);
    flush = fl; hold = hd;
    #1;
    o.st = stall;
    @(posedge clk); #1;
    o.v  = ex_valid;
    o.rd = ex_valid ? ex_wr_rd : 5'd0;
    o.rw = ex_reg_write;
    o.mr = ex_mem_read;
    o.um = USE_MEM_BACK;
    o.uw = USE_WB_BACK;
    if (!o.st) pc++;
  endtask

  task automatic test_reset();
    rst = 1'b1; hold = 1'b0; flush = 1'b0;
    drive_instr(alu(5'd7, 5'd8, 5'd9));
    id_mem_read = 1'b1;
    @(posedge clk); #1;
    drive_instr(lw(5'd3, 5'd1));
    @(posedge clk); #1;
    n_checks++;
    if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write} !== 4'b0) begin
      n_fail++; $display("FAIL reset_ctrl got %b required 0000",
                         {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write});
    end
    n_checks++;
    if ({ex_rs, ex_rt, ex_wr_rd, ex_alu_op, ex_rd1, ex_rd2, ex_imm} !== '0) begin
      n_fail++; $display("FAIL reset_data got rd1=%h rd2=%h imm=%h rs=%0d rt=%0d wr=%0d op=%0d required 0",
                         ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_wr_rd, ex_alu_op);
    end
    n_checks++;
    if ({USE_MEM_BACK, USE_WB_BACK, stall} !== 3'b000) begin
      n_fail++; $display("FAIL reset_fwd_stall got %b required 000",
                         {USE_MEM_BACK, USE_WB_BACK, stall});
    end
    rst = 1'b0;
  endtask

  task automatic test_capture();
    logic [31:0] r1, r2, im;
    do_reset();
    id_valid = 1'b1; id_rs = 5'd11; id_rt = 5'd12; id_use_rs = 1'b1; id_use_rt = 1'b0;
    id_wr_rd = 5'd13; id_reg_write = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b1;
    id_alu_op = 4'd9;
    r1 = $urandom; r2 = $urandom; im = $urandom;
    id_rd1 = r1; id_rd2 = r2; id_imm = im;
    @(posedge clk); #1;
    n_checks++;
    if ({ex_rd1, ex_rd2, ex_imm} !== {r1, r2, im}) begin
      n_fail++; $display("FAIL capture_data got %h %h %h required %h %h %h",
                         ex_rd1, ex_rd2, ex_imm, r1, r2, im);
    end
    n_checks++;
    if ({ex_valid, ex_rs, ex_rt, ex_wr_rd, ex_alu_op, ex_reg_write, ex_mem_read, ex_mem_write}
        !== {1'b1, 5'd11, 5'd12, 5'd13, 4'd9, 1'b0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL capture_ctrl got v=%b rs=%0d rt=%0d wr=%0d op=%0d rw=%b mr=%b mw=%b required v=1 rs=11 rt=12 wr=13 op=9 rw=0 mr=0 mw=1",
                         ex_valid, ex_rs, ex_rt, ex_wr_rd, ex_alu_op, ex_reg_write, ex_mem_read, ex_mem_write);
    end
    id_valid = 1'b0; id_reg_write = 1'b1; id_mem_read = 1'b1; id_mem_write = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write} !== 4'b0000) begin
      n_fail++; $display("FAIL capture_invalid got %b required 0000",
                         {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write});
    end
  endtask

  task automatic test_back_to_back();
    obs_t o, x;
    obs_t tab [6] = '{e(0,1,3,1,1,0,0), e(1,0,0,0,0,0,0), e(1,0,0,0,0,0,1),
                      e(0,1,4,1,0,0,0), e(0,0,0,0,0,1,0), e(0,0,0,0,0,0,1)};
    prog = '{lw(5'd3, 5'd1), alu(5'd4, 5'd3, 5'd5)};
    pc = 0; do_reset();
    for (int k = 0; k < 6; k++) begin
      sb.push_back(tab[k]);
      step(1'b0, 1'b0, o);
      x = sb.pop_front();
      n_checks++;
      if (o !== x) begin n_fail++; $display("FAIL back_to_back cyc %0d got %b required %b", k, o, x); end
    end
  endtask

  task automatic test_one_gap();
    obs_t o, x;
    obs_t tab [5] = '{e(0,1,3,1,1,0,0), e(0,1,7,1,0,0,0), e(1,0,0,0,0,1,1),
                      e(0,1,4,1,0,0,1), e(0,0,0,0,0,1,0)};
    prog = '{lw(5'd3, 5'd1), alu(5'd7, 5'd1, 5'd2), alu(5'd4, 5'd3, 5'd5)};
    pc = 0; do_reset();
    for (int k = 0; k < 5; k++) begin
      sb.push_back(tab[k]);
      step(1'b0, 1'b0, o);
      x = sb.pop_front();
      n_checks++;
      if (o !== x) begin n_fail++; $display("FAIL one_gap cyc %0d got %b required %b", k, o, x); end
    end
  endtask

  task automatic test_reg_zero();
    obs_t o, x;
    obs_t tab [4] = '{e(0,1,0,1,1,0,0), e(0,1,4,1,0,0,0), e(0,0,0,0,0,1,1),
                      e(0,0,0,0,0,0,1)};
    prog = '{lw(5'd0, 5'd1), alu(5'd4, 5'd0, 5'd5)};
    pc = 0; do_reset();
    for (int k = 0; k < 4; k++) begin
      sb.push_back(tab[k]);
      step(1'b0, 1'b0, o);
      x = sb.pop_front();
      n_checks++;
      if (o !== x) begin n_fail++; $display("FAIL reg_zero cyc %0d got %b required %b", k, o, x); end
    end
  endtask

  task automatic test_alu_producer();
    obs_t o, x;
    obs_t tab [4] = '{e(0,1,3,1,0,0,0), e(0,1,6,1,0,1,0), e(0,0,0,0,0,1,1),
                      e(0,0,0,0,0,0,1)};
    prog = '{alu(5'd3, 5'd1, 5'd2), alu(5'd6, 5'd3, 5'd3)};
    pc = 0; do_reset();
    for (int k = 0; k < 4; k++) begin
      sb.push_back(tab[k]);
      step(1'b0, 1'b0, o);
      x = sb.pop_front();
      n_checks++;
      if (o !== x) begin n_fail++; $display("FAIL alu_producer cyc %0d got %b required %b", k, o, x); end
    end
  endtask

  task automatic test_store_dep();
    obs_t o, x;
    obs_t tab [5] = '{e(0,1,3,1,1,0,0), e(1,0,0,0,0,0,0), e(1,0,0,0,0,0,1),
                      e(0,1,0,0,0,0,0), e(0,0,0,0,0,1,0)};
    prog = '{lw(5'd3, 5'd1), sw(5'd3, 5'd2)};
    pc = 0; do_reset();
    for (int k = 0; k < 5; k++) begin
      sb.push_back(tab[k]);
      step(1'b0, 1'b0, o);
      x = sb.pop_front();
      n_checks++;
      if (o !== x) begin n_fail++; $display("FAIL store_dep cyc %0d got %b required %b", k, o, x); end
    end
  endtask

  task automatic test_flush();
    obs_t o, x;
    obs_t tab [3] = '{e(0,1,3,1,1,0,0), e(0,0,0,0,0,0,0), e(0,0,0,0,0,0,1)};
    logic fl [3] = '{1'b0, 1'b1, 1'b0};
    prog = '{lw(5'd3, 5'd1), alu(5'd4, 5'd3, 5'd5)};
    pc = 0; do_reset();
    for (int k = 0; k < 3; k++) begin
      sb.push_back(tab[k]);
      step(fl[k], 1'b0, o);
      x = sb.pop_front();
      n_checks++;
      if (o !== x) begin n_fail++; $display("FAIL flush cyc %0d got %b required %b", k, o, x); end
    end
  endtask

  task automatic test_hold();
    obs_t o, x;
    obs_t tab [10] = '{e(0,1,3,1,1,0,0), e(1,1,3,1,1,0,0), e(1,1,3,1,1,0,0),
                       e(1,1,3,1,1,0,0), e(1,0,0,0,0,0,0), e(1,0,0,0,0,0,1),
                       e(0,1,4,1,0,0,0), e(0,0,0,0,0,1,0), e(1,0,0,0,0,1,0),
                       e(0,0,0,0,0,0,1)};
    logic hd [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    prog = '{lw(5'd3, 5'd1), alu(5'd4, 5'd3, 5'd5)};
    pc = 0; do_reset();
    for (int k = 0; k < 10; k++) begin
      sb.push_back(tab[k]);
      step(1'b0, hd[k], o);
      x = sb.pop_front();
      n_checks++;
      if (o !== x) begin n_fail++; $display("FAIL hold cyc %0d got %b required %b", k, o, x); end
    end
  endtask

  task automatic test_reset_mid_stall();
    obs_t o;
    prog = '{lw(5'd3, 5'd1), alu(5'd4, 5'd3, 5'd5)};
    pc = 0; do_reset();
    step(1'b0, 1'b0, o);
    step(1'b0, 1'b0, o);
    n_checks++;
    if (o.st !== 1'b1) begin n_fail++; $display("FAIL rst_mid_stall_pre got %b required 1", o.st); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({ex_valid, USE_MEM_BACK, USE_WB_BACK, stall} !== 4'b0000) begin
      n_fail++; $display("FAIL rst_mid_stall_clear got %b required 0000",
                         {ex_valid, USE_MEM_BACK, USE_WB_BACK, stall});
    end
    step(1'b0, 1'b0, o);
    n_checks++;
    if (o !== e(0,1,4,1,0,0,0)) begin
      n_fail++; $display("FAIL rst_mid_stall_resume got %b required %b", o, e(0,1,4,1,0,0,0));
    end
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; flush = 1'b0;
    drive_instr('0);
    #1;
    test_reset();
    test_capture();
    test_back_to_back();
    test_one_gap();
    test_reg_zero();
    test_alu_producer();
    test_store_dep();
    test_flush();
    test_hold();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
